// File: rtl/burst_pkg.sv
// Shared definitions for the burst packer and the asymmetric_fifo
// instantiation site that consumes its bursts.
//   burst_state_e      : packer state (FILL collects items, PUSH offers a burst)
//   BURST_N_IN_DEFAULT : default number of items per burst
package burst_pkg;

  typedef enum logic {
    FILL = 1'b0,
    PUSH = 1'b1
  } burst_state_e;

  localparam int BURST_N_IN_DEFAULT = 4;

endpackage : burst_pkg

// File: rtl/burst_packer_idle_counter.sv
// Up-counter with synchronous clear used as the idle timer of burst_packer.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear (wins over en_i)
//   en_i          : count enable
//   q_o           : current count
module burst_packer_idle_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (clear_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= q_q + WIDTH'(1);
    end
  end

  assign q_o = q_q;

endmodule : burst_packer_idle_counter

// File: rtl/burst_packer.sv
// Collects N_IN items of DATA_WIDTH bits into one wide burst and pushes it
// to a downstream asymmetric FIFO. Partial bursts can be drained (padded
// with PAD_VALUE, mask bits left clear) or flushed (discarded).
// Optional feature: define BURST_PACKER_TIMEOUT_EN to auto-drain a partial
// burst after TIMEOUT idle cycles.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : discard partial burst, highest priority
//   valid_i/ready_o/data_i : upstream item handshake
//   drain_i       : push the partial burst now
//   data_o        : burst, slot 0 in the least significant DATA_WIDTH bits
//   valid_mask_o  : per-slot real-data flag
//   push_o        : to FIFO push_i; full_i from FIFO full_o
//   count_o       : slots currently filled
module burst_packer
  import burst_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    N_IN       = BURST_N_IN_DEFAULT,
  parameter int                    TIMEOUT    = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DATA_WIDTH-1:0]      data_i,
  input  logic                       drain_i,
  output logic [N_IN*DATA_WIDTH-1:0] data_o,
  output logic [N_IN-1:0]            valid_mask_o,
  output logic                       push_o,
  input  logic                       full_i,
  output logic [$clog2(N_IN+1)-1:0]  count_o
);

  localparam int CW = $clog2(N_IN + 1);

  if (N_IN < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("burst_packer: N_IN and TIMEOUT must both be at least 1");
  end

  typedef logic [N_IN-1:0][DATA_WIDTH-1:0] slots_t;

  burst_state_e      state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [N_IN-1:0]   mask_q, mask_d;
  slots_t            slots_q, slots_d;

  logic accept;
  logic timeout_hit;
  logic drain_req;

  assign ready_o = !flush_i && ((state_q == FILL) || !full_i);
  assign accept  = valid_i && ready_o;

`ifdef BURST_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_q;
  logic          idle_en;
  logic          idle_clear;

  assign idle_en    = (state_q == FILL) && (count_q != '0) && !accept && !flush_i;
  assign idle_clear = accept || (state_q == PUSH) || flush_i;

  burst_packer_idle_counter #(
    .WIDTH (TW)
  ) u_idle_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (idle_clear),
    .en_i    (idle_en),
    .q_o     (idle_q)
  );

  // Fires on the idle cycle that would bring the counter to TIMEOUT, so the
  // burst is offered right after the TIMEOUT-th idle cycle.
  assign timeout_hit = idle_en && (idle_q == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign drain_req = drain_i || timeout_hit;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case/if tree can leave one unassigned and infer a latch.
    state_d = state_q;
    count_d = count_q;
    mask_d  = mask_q;
    slots_d = slots_q;

    if (flush_i) begin
      state_d = FILL;
      count_d = '0;
      mask_d  = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            for (int i = 0; i < N_IN; i++) begin
              if (CW'(i) == count_q) begin
                slots_d[i] = data_i;
                mask_d[i]  = 1'b1;
              end
            end
            count_d = count_q + CW'(1);
          end
          if (count_d == CW'(N_IN)) begin
            state_d = PUSH;
          end else if (drain_req && (count_d != '0)) begin
            // Pad only the slots past the last real item; mask bits stay 0.
            for (int i = 0; i < N_IN; i++) begin
              if (CW'(i) >= count_d) begin
                slots_d[i] = PAD_VALUE;
              end
            end
            state_d = PUSH;
          end
        end
        PUSH: begin
          // ready_o follows ~full_i here, so an accept implies the burst
          // is taken in the same cycle and the item starts the next one.
          if (!full_i) begin
            state_d = FILL;
            count_d = '0;
            mask_d  = '0;
            if (accept) begin
              slots_d[0] = data_i;
              mask_d[0]  = 1'b1;
              count_d    = CW'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: the slot registers are reset along with control because data_o
  // must read all-zero out of reset; a plain storage array would not be.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
      count_q <= '0;
      mask_q  <= '0;
      slots_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the same pre-edge values regardless of statement order.
      state_q <= state_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      slots_q <= slots_d;
    end
  end

  assign push_o       = (state_q == PUSH);
  assign data_o       = slots_q;
  assign valid_mask_o = mask_q;
  assign count_o      = count_q;

endmodule : burst_packer

// File: tb/tb_burst_packer.sv
// Self-checking bench for burst_packer (N_IN=4, DATA_WIDTH=32,
// PAD_VALUE=32'hDEADBEEF). Expected bursts go into a scoreboard queue when
// stimulus is issued; a monitor pops and compares whenever a burst is taken.
module tb_burst_packer;

  localparam int          DW  = 32;
  localparam int          N   = 4;
  localparam logic [31:0] PAD = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [N*DW-1:0] data;
    logic [N-1:0]    mask;
  } burst_t;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i, valid_i, drain_i, full_i;
  logic            ready_o, push_o;
  logic [DW-1:0]   data_i;
  logic [N*DW-1:0] data_o;
  logic [N-1:0]    valid_mask_o;
  logic [2:0]      count_o;

  int     checks   = 0;
  int     failures = 0;
  burst_t sb_q[$];

  burst_packer #(
    .DATA_WIDTH (DW),
    .N_IN       (N),
    .TIMEOUT    (16),
    .PAD_VALUE  (PAD)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_i       (data_i),
    .drain_i      (drain_i),
    .data_o       (data_o),
    .valid_mask_o (valid_mask_o),
    .push_o       (push_o),
    .full_i       (full_i),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [N*DW-1:0] act,
                       input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a burst is taken on the edge after a negedge with push && ~full.
  always @(negedge clk_i) begin
    if (rst_ni && push_o && !full_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_push: got data %h mask %b expected no push",
                 data_o, valid_mask_o);
      end else begin
        burst_t e;
        e = sb_q.pop_front();
        check("burst_data", data_o, e.data);
        check("burst_mask", {{(N*DW-N){1'b0}}, valid_mask_o}, {{(N*DW-N){1'b0}}, e.mask});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic put(input logic [31:0] d);
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic expect_burst(input logic [N*DW-1:0] d, input logic [N-1:0] m);
    burst_t b;
    b.data = d;
    b.mask = m;
    sb_q.push_back(b);
  endtask

  initial begin
    int n;
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    drain_i = 1'b0;
    full_i  = 1'b0;
    data_i  = '0;

    // Reset state
    #12;
    check("rst_count", 128'(count_o), 128'd0);
    check("rst_mask", 128'(valid_mask_o), 128'd0);
    check("rst_push", 128'(push_o), 128'd0);
    check("rst_data", data_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("ready_after_reset", 128'(ready_o), 128'd1);
    tick();

    // Full burst A..D, push one cycle after the 4th accept
    expect_burst({32'hD, 32'hC, 32'hB, 32'hA}, 4'b1111);
    put(32'hA);
    put(32'hB);
    put(32'hC);
    check("no_push_before_fourth", 128'(push_o), 128'd0);
    put(32'hD);
    check("push_latency", 128'(push_o), 128'd1);
    tick();
    check("push_one_cycle", 128'(push_o), 128'd0);
    check("count_after_take", 128'(count_o), 128'd0);

    // Back-pressure: burst held while full_i, drain_i ignored in PUSH
    full_i = 1'b1;
    put(32'h10);
    put(32'h11);
    put(32'h12);
    put(32'h13);
    for (int i = 0; i < 3; i++) begin
      drain_i = (i == 1);
      #1;
      check("held_push", 128'(push_o), 128'd1);
      check("held_ready", 128'(ready_o), 128'd0);
      check("held_data", data_o, {32'h13, 32'h12, 32'h11, 32'h10});
      tick();
    end
    drain_i = 1'b0;
    expect_burst({32'h13, 32'h12, 32'h11, 32'h10}, 4'b1111);
    full_i  = 1'b0;
    valid_i = 1'b1;
    data_i  = 32'hE;
    #1;
    check("ready_when_not_full", 128'(ready_o), 128'd1);
    tick();
    valid_i = 1'b0;
    check("take_accept_count", 128'(count_o), 128'd1);
    check("take_accept_mask", 128'(valid_mask_o), 128'b0001);
    check("take_accept_slot0", 128'(data_o[31:0]), 128'hE);
    check("take_accept_push", 128'(push_o), 128'd0);

    // Flush the single pending item, ready_o low during flush
    flush_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 32'h77;
    #1;
    check("ready_during_flush", 128'(ready_o), 128'd0);
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_count", 128'(count_o), 128'd0);
    check("flush_mask", 128'(valid_mask_o), 128'd0);

    // Drain with empty burst is ignored
    drain_i = 1'b1;
    tick();
    drain_i = 1'b0;
    check("empty_drain_push", 128'(push_o), 128'd0);

    // Two items then drain
    expect_burst({PAD, PAD, 32'h2, 32'h1}, 4'b0011);
    put(32'h1);
    put(32'h2);
    drain_i = 1'b1;
    tick();
    drain_i = 1'b0;
    check("drain_push", 128'(push_o), 128'd1);
    tick();

    // Drain together with an accept
    expect_burst({PAD, PAD, 32'h6, 32'h5}, 4'b0011);
    put(32'h5);
    drain_i = 1'b1;
    put(32'h6);
    drain_i = 1'b0;
    check("drain_accept_push", 128'(push_o), 128'd1);
    tick();

    // Drain together with the accept that completes the burst
    expect_burst({32'h24, 32'h23, 32'h22, 32'h21}, 4'b1111);
    put(32'h21);
    put(32'h22);
    put(32'h23);
    drain_i = 1'b1;
    put(32'h24);
    drain_i = 1'b0;
    check("drain_full_push", 128'(push_o), 128'd1);
    tick();

    // Three items then flush with valid_i: item dropped, no push
    put(32'h31);
    put(32'h32);
    put(32'h33);
    flush_i = 1'b1;
    put(32'h99);
    flush_i = 1'b0;
    check("flush3_count", 128'(count_o), 128'd0);
    check("flush3_mask", 128'(valid_mask_o), 128'd0);
    check("flush3_push", 128'(push_o), 128'd0);
    expect_burst({32'h44, 32'h43, 32'h42, 32'h41}, 4'b1111);
    put(32'h41);
    put(32'h42);
    put(32'h43);
    put(32'h44);
    tick();

    // Idle partial burst
`ifdef BURST_PACKER_TIMEOUT_EN
    expect_burst({PAD, PAD, PAD, 32'h55}, 4'b0001);
    put(32'h55);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (push_o) break;
      n++;
    end
    check("idle_cycles_before_push", 128'(n), 128'd16);
    tick();
`else
    put(32'h55);
    n = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (push_o) n++;
    end
    check("no_timeout_push", 128'(n), 128'd0);
    check("idle_count_kept", 128'(count_o), 128'd1);
    #2;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
`endif

    // Asynchronous reset while in PUSH
    full_i = 1'b1;
    put(32'h61);
    put(32'h62);
    put(32'h63);
    put(32'h64);
    check("pre_reset_push", 128'(push_o), 128'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_push", 128'(push_o), 128'd0);
    check("async_rst_count", 128'(count_o), 128'd0);
    check("async_rst_mask", 128'(valid_mask_o), 128'd0);
    check("async_rst_data", data_o, '0);
    full_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    tick();

    check("scoreboard_empty", 128'(sb_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_burst_packer

// File: doc/burst_packer.md
BURST_PACKER -- requirements
Module: burst_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, item width in bits.
REQ-002 SHALL have parameter N_IN, default 4, items per output burst (1..DEPTH of the downstream asymmetric_fifo).
REQ-003 SHALL have parameter TIMEOUT, default 16, idle cycles before a partial burst is auto-drained (used only with the macro in REQ-024).
REQ-004 SHALL have parameter PAD_VALUE, default '0, fill value for unwritten slots.
REQ-005 SHALL have ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- flush_i, in, 1, synchronous discard of the partial burst.
- valid_i, in, 1, upstream item valid.
- ready_o, out, 1, item accepted when valid_i && ready_o.
- data_i, in, DATA_WIDTH, upstream item.
- drain_i, in, 1, force-push the partial burst.
- data_o, out, N_IN x DATA_WIDTH, burst to the FIFO data_i.
- valid_mask_o, out, N_IN, per-slot real-data flag.
- push_o, out, 1, to the FIFO push_i.
- full_i, in, 1, from the FIFO full_o.
- count_o, out, $clog2(N_IN+1), slots currently filled.

Function
REQ-006 SHALL implement two states: FILL and PUSH.
REQ-007 In FILL, ready_o SHALL be 1; an accepted item SHALL be written to slot count_o, that slot's mask bit set, and count incremented.
REQ-008 The accept that makes count equal to N_IN SHALL move the block to PUSH on the next cycle; push_o SHALL equal (state==PUSH).
REQ-009 Latency: the N_IN-th item accepted at cycle t SHALL produce push_o=1 at cycle t+1.
REQ-010 In PUSH, data_o and valid_mask_o SHALL stay stable until the burst is taken (push_o && ~full_i).
REQ-011 In PUSH, ready_o SHALL equal ~full_i.
REQ-012 When the burst is taken with no accept in that cycle, the next state SHALL be FILL with count=0 and mask cleared.
REQ-013 When the burst is taken and an item is accepted in the same cycle, that item SHALL go to slot 0, count SHALL be 1 and mask SHALL be 0...01, with next state FILL.
REQ-014 While full_i=1 in PUSH, the block SHALL hold its state and assert ready_o=0.
REQ-015 drain_i in FILL with count>0 SHALL fill slots count..N_IN-1 with PAD_VALUE, leave their mask bits at 0, and enter PUSH.
REQ-016 drain_i with count=0 and no accept SHALL be ignored.
REQ-017 drain_i together with an accept SHALL first store the item, then pad the remaining slots; if the accept fills the burst, behaviour SHALL be identical to REQ-008.
REQ-018 drain_i in PUSH SHALL have no effect.
REQ-019 flush_i SHALL have priority over all other events: next state FILL, count 0, mask 0, idle counter 0, same-cycle accept dropped.
REQ-020 While flush_i=1, ready_o SHALL be 0.
REQ-021 count SHALL never exceed N_IN, and slot indexing SHALL never wrap within a burst.

Reset
REQ-022 On rst_ni low, asynchronously: state FILL, count_o 0, valid_mask_o 0, data_o all 0, push_o 0, idle counter 0.
REQ-023 After reset release, ready_o SHALL be 1.

Configuration
REQ-024 With BURST_PACKER_TIMEOUT_EN defined, an idle counter SHALL increment each FILL cycle with count>0 and no accept, and clear on any accept, push or flush.
REQ-025 With BURST_PACKER_TIMEOUT_EN defined, the idle counter reaching TIMEOUT SHALL trigger the drain behaviour of REQ-015.
REQ-026 Without BURST_PACKER_TIMEOUT_EN, no idle counter SHALL exist and TIMEOUT SHALL be unused; partial bursts leave only via fill, drain_i or flush_i.

Structure
REQ-027 The state enum typedef and the default N_IN SHALL live in a shared package, burst_pkg, which is also used by the asymmetric_fifo instantiation site.
REQ-028 The idle timer SHALL use the common_cells counter sub-module, instantiated only under the macro; no other sub-module.

Verification
REQ-029 N_IN=4, items 0xA..0xD on consecutive cycles with full_i=0 -> push_o=1 exactly one cycle later, data_o={D,C,B,A}, mask 4'b1111.
REQ-030 Full burst pending with full_i=1 for 3 cycles -> push_o held, data_o stable, ready_o=0; full_i drops with valid_i=1 and data 0xE -> next cycle count_o=1, mask 4'b0001.
REQ-031 Two items 0x1, 0x2 then drain_i -> push_o next cycle, data_o={PAD,PAD,2,1}, mask 4'b0011.
REQ-032 Macro on, TIMEOUT=16, one item then idle -> push_o asserted after 16 idle cycles, mask 4'b0001; macro off -> no push after 100 idle cycles.
REQ-033 Three items then flush_i together with valid_i -> count_o=0, mask 0, no push, item dropped.
REQ-034 Reset asserted while in PUSH -> push_o=0, count_o=0 immediately, without waiting for a clock edge.
